// File: rtl/booth4_seq_mul.sv
// booth4_seq_mul: iterative radix-4 Booth multiplier, two multiplier bits per cycle.
// Valid/ready handshake on request and result, per-operand signedness, high/low
// half select and flush. Define MUL_WORD_EN to add the op_word port for
// half-width (word) operations with a sign-extended low-half result.
module booth4_seq_mul #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            rs1_signed,
  input  logic            rs2_signed,
  input  logic            sel_high,
`ifdef MUL_WORD_EN
  input  logic            op_word,
`endif
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] mul_result
);

  localparam int unsigned ITER   = (XLEN + 2) / 2;
  localparam int unsigned HW     = XLEN / 2;
  localparam int unsigned ITER_W = (HW + 2) / 2;
  // Bit position in lo where the word product's LSB lands after ITER_W shifts.
  localparam int unsigned WOFF   = XLEN + 2 - 2 * ITER_W;
  localparam int unsigned CW     = $clog2(ITER + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q;
  logic [XLEN+3:0]     hi_q;
  logic [XLEN+1:0]     lo_q;
  logic                ybit_q;
  logic [XLEN+1:0]     x_q;
  logic [CW-1:0]       cnt_q;
  logic                sel_hi_q;
`ifdef MUL_WORD_EN
  logic                word_q;
`endif

  logic                word_sel;
  logic [XLEN+1:0]     rs1_ext;
  logic [XLEN+1:0]     rs2_ext;
  logic [XLEN+3:0]     x_wide;
  logic [XLEN+3:0]     digit;
  logic [XLEN+3:0]     sum;
  logic [XLEN+3:0]     hi_nxt;
  logic [XLEN+1:0]     lo_nxt;
  logic [CW-1:0]       last_cnt;
  logic [XLEN-1:0]     res_sel;

  // Operand extension to XLEN+2 bits, honouring per-operand signedness and word mode.
  always_comb begin
    word_sel = 1'b0;
    rs1_ext  = {{2{rs1_data[XLEN-1] & rs1_signed}}, rs1_data};
    rs2_ext  = {{2{rs2_data[XLEN-1] & rs2_signed}}, rs2_data};
`ifdef MUL_WORD_EN
    word_sel = word_q;
    if (op_word) begin
      rs1_ext = {{(HW + 2){rs1_data[HW-1] & rs1_signed}}, rs1_data[HW-1:0]};
      rs2_ext = {{(HW + 2){rs2_data[HW-1] & rs2_signed}}, rs2_data[HW-1:0]};
    end
`endif
  end

  // Booth digit selection, partial-sum add and 2-bit arithmetic shift.
  always_comb begin
    x_wide = {{2{x_q[XLEN+1]}}, x_q};
    digit  = '0;
    unique case ({lo_q[1:0], ybit_q})
      3'b001, 3'b010: digit = x_wide;
      3'b011:         digit = x_wide << 1;
      3'b100:         digit = -(x_wide << 1);
      3'b101, 3'b110: digit = -x_wide;
      default:        digit = '0;
    endcase
    sum    = hi_q + digit;
    hi_nxt = {{2{sum[XLEN+3]}}, sum[XLEN+3:2]};
    lo_nxt = {sum[1:0], lo_q[XLEN+1:2]};
  end

  // Final result selection from the accumulated {hi, lo} product.
  always_comb begin
    last_cnt = word_sel ? CW'(ITER_W) : CW'(ITER);
    if (word_sel) begin
      res_sel = {{HW{lo_q[WOFF+HW-1]}}, lo_q[WOFF +: HW]};
    end else if (sel_hi_q) begin
      res_sel = {hi_q[XLEN-3:0], lo_q[XLEN+1:XLEN]};
    end else begin
      res_sel = lo_q[XLEN-1:0];
    end
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      mul_result <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      ybit_q     <= 1'b0;
      x_q        <= '0;
      cnt_q      <= '0;
      sel_hi_q   <= 1'b0;
`ifdef MUL_WORD_EN
      word_q     <= 1'b0;
`endif
    end else if (flush) begin
      // Flush wins over everything, including a same-cycle in_valid.
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q  <= StBusy;
            in_ready <= 1'b0;
            hi_q     <= '0;
            lo_q     <= rs2_ext;
            ybit_q   <= 1'b0;
            x_q      <= rs1_ext;
            cnt_q    <= '0;
            sel_hi_q <= sel_high;
`ifdef MUL_WORD_EN
            word_q   <= op_word;
`endif
          end
        end
        StBusy: begin
          // One extra cycle after the last iteration registers the result.
          if (cnt_q == last_cnt) begin
            state_q    <= StDone;
            out_valid  <= 1'b1;
            mul_result <= res_sel;
          end else begin
            hi_q   <= hi_nxt;
            lo_q   <= lo_nxt;
            ybit_q <= lo_q[1];
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_seq_mul.sv
// Directed bench for booth4_seq_mul (XLEN=64): products, latency, backpressure,
// flush and asynchronous reset. Word-mode vector is added when MUL_WORD_EN is defined.
module tb_booth4_seq_mul;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_signed;
  logic            rs2_signed;
  logic            sel_high;
`ifdef MUL_WORD_EN
  logic            op_word;
`endif
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] mul_result;

  int checks;
  int failures;

  booth4_seq_mul #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_signed (rs1_signed),
    .rs2_signed (rs2_signed),
    .sel_high   (sel_high),
`ifdef MUL_WORD_EN
    .op_word    (op_word),
`endif
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mul_result (mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request, wait for the result, check latency and value, then retire it.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s1, input logic s2, input logic sh,
                        input int exp_lat, input logic [63:0] exp_res);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    rs1_data   = a;
    rs2_data   = b;
    rs1_signed = s1;
    rs2_signed = s2;
    sel_high   = sh;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rs1_data = '1;
    rs2_data = '1;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, mul_result, exp_res);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_retired"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    int          spurious;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    rs1_data   = '0;
    rs2_data   = '0;
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    sel_high   = 1'b0;
`ifdef MUL_WORD_EN
    op_word    = 1'b0;
`endif
    flush      = 1'b0;
    out_ready  = 1'b0;

    // Reset state.
    #12;
    check("rst_outputs", {mul_result[61:0], out_valid, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Main function.
    run_op("u3x5",      64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 34, 64'h0000_0000_0000_000F);
    run_op("sm1m1_lo",  '1, '1, 1'b1, 1'b1, 1'b0, 34, 64'h0000_0000_0000_0001);
    run_op("sm1m1_hi",  '1, '1, 1'b1, 1'b1, 1'b1, 34, 64'h0000_0000_0000_0000);
    run_op("umax2_hi",  '1, '1, 1'b0, 1'b0, 1'b1, 34, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("umax2_lo",  '1, '1, 1'b0, 1'b0, 1'b0, 34, 64'h0000_0000_0000_0001);
    run_op("su_m2x3_hi", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b0, 1'b1, 34,
           64'hFFFF_FFFF_FFFF_FFFF);
    run_op("su_m2x3_lo", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b0, 1'b0, 34,
           64'hFFFF_FFFF_FFFF_FFFA);
    // (-2^63)^2 = 2^126
    run_op("smin2_hi",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 34,
           64'h4000_0000_0000_0000);
    // -1 * (2^64-1) = -2^64 + 1
    run_op("su_m1xmax_hi", '1, '1, 1'b1, 1'b0, 1'b1, 34, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("su_m1xmax_lo", '1, '1, 1'b1, 1'b0, 1'b0, 34, 64'h0000_0000_0000_0001);

    // Backpressure: result held while out_ready is low; new requests ignored.
    @(negedge clk);
    rs1_data = 64'd7; rs2_data = 64'd6; rs1_signed = 1'b0; rs2_signed = 1'b0; sel_high = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
    check("bp_first", mul_result, 64'd42);
    held = mul_result;
    rs1_data = 64'd9; rs2_data = 64'd9; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {mul_result[61:0], out_valid, in_ready}, {held[61:0], 1'b1, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {62'd0, out_valid, in_ready}, 64'd1);

    // Flush in cycle 10 of BUSY, with a concurrent in_valid that must be ignored.
    @(negedge clk);
    rs1_data = 64'd11; rs2_data = 64'd13; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", {62'd0, out_valid, in_ready}, 64'd1);
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("flush_no_valid", 64'(spurious), 64'd0);
    run_op("post_flush", 64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 34, 64'h0000_0000_0000_000F);

    // Asynchronous reset mid-BUSY: outputs return to reset values without a clock edge.
    @(negedge clk);
    rs1_data = 64'd100; rs2_data = 64'd100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_outputs", {mul_result[61:0], out_valid, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("arst_no_valid", 64'(spurious), 64'd0);
    run_op("post_rst", 64'd3, 64'd5, 1'b0, 1'b0, 1'b0, 34, 64'h0000_0000_0000_000F);

`ifdef MUL_WORD_EN
    op_word = 1'b1;
    run_op("word_s", 64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, 1'b1, 1'b0, 18,
           64'hFFFF_FFFF_FFFF_FFFE);
    op_word = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global timeout so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
